wallace_csa_reducer: RTL and testbench
======================================

Name: wallace_csa_reducer

Overview:
- Sequential Wallace-tree reduction stage for the 16x16 unsigned multiplier.
- Directly upstream of the 32-bit final carry-propagate adder; produces the two 32-bit operands that adder consumes.
- Generates 16 partial-product rows and reduces them with one 3:2 carry-save layer per clock until two rows remain.
- Presents the two rows with a valid/ready handshake; the adder's sum of the pair is the product.

Parameters:
- N, 16, operand width. Only 16 is supported, because the output pair is 2N = 32 bits to match the downstream 32-bit adder.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands this cycle
- a  input  16  multiplicand, unsigned
- b  input  16  multiplier, unsigned
- out_valid  output  1  sum_vec/carry_vec hold a finished reduction
- out_ready  input  1  downstream adder consumes the pair
- sum_vec  output  32  reduced row 0
- carry_vec  output  32  reduced row 1, already weight-aligned (no further shift needed)
- busy  output  1  high in LOAD..DONE

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE; all 16 row registers = 0; row count = 0.
  - in_ready = 1, out_valid = 0, sum_vec = carry_vec = 0, busy = 0.
  - Takes effect immediately, mid-reduction included; any in-flight operation is discarded with no output.
- States: IDLE, REDUCE, DONE.
- Accept:
  - A transfer occurs on a rising edge with in_valid & in_ready.
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - On accept, row i <= (b[i] ? a : 0) << i, zero-extended to 32 bits, for i = 0..15. Row count <= 16; state <= REDUCE.
- REDUCE, per clock:
  - Rows are grouped in threes from row 0. Each full group (x,y,z) becomes s = x^y^z and c = maj(x,y,z) << 1, truncated to 32 bits.
  - Leftover 1-2 rows pass through unchanged. Results are packed from row 0 upward; vacated rows are cleared to 0.
  - Row count sequence: 16, 11, 8, 6, 4, 3, 2 (6 layers).
  - When the new count is 2, state <= DONE.
- DONE:
  - out_valid = 1; sum_vec = row0, carry_vec = row1, both stable until transfer.
  - On out_valid & out_ready: if in_valid is also high, a new operand pair is accepted on the same edge (-> REDUCE). Otherwise -> IDLE.
- Latency: accept edge E0; out_valid is high after edge E6. Throughput is one product per 7 cycles with back-to-back handshake.
- Outputs in IDLE/REDUCE: out_valid = 0, sum_vec/carry_vec = 0. They are driven from registers, with no combinational path from a/b.
- Arithmetic invariant:
  - After every layer, the unsigned sum of all rows = a*b exactly.
  - A carry out of bit 31 is impossible because a*b < 2^32; dropping it is lossless.
  - Final: sum_vec + carry_vec (33-bit) = a*b, with bit 32 = 0, so the downstream overflow flag must be 0.
- in_valid while busy and not in DONE & out_ready: ignored; operands must be held by the upstream.
- a/b changing after accept: no effect.

Test Plan:
- Reset, then a=3, b=5 accepted:
  - out_valid rises exactly 6 edges later.
  - sum_vec+carry_vec = 15; the adder's sum = 0x0000000F with overflow 0.
- a=0xFFFF, b=0xFFFF: pair sums to 0xFFFE0001; bit 32 of the 33-bit sum = 0.
- a=0x1234, b=0: sum_vec = carry_vec = 0 at DONE. a=1, b=0xABCD: pair sums to 0xABCD.
- Backpressure: out_ready low for 10 cycles after DONE:
  - out_valid stays 1 and the vectors are unchanged.
  - in_ready = 0 throughout; out_ready high then completes the transfer.
- Back-to-back: in_valid held with new operands (0x00FF, 0x0101) during the DONE & out_ready edge:
  - The new accept occurs on that edge.
  - The next out_valid follows 6 edges later with sum 0x0000FFFF.
- rst_n pulsed low at layer 3 of a=0xAAAA, b=0x5555:
  - out_valid, busy and the vectors go to 0 immediately, and in_ready goes to 1.
  - No output is produced for that operation.
  - A fresh 7x9 afterwards yields 63.

Source files
------------

// File: rtl/wallace_csa_reducer.sv
// Sequential Wallace-tree reducer for a 16x16 unsigned multiply: loads 16 partial-product
// rows, applies one 3:2 carry-save layer per clock, and hands the final row pair downstream.
module wallace_csa_row #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  logic [W-1:0] i_z,
  output logic [W-1:0] o_s,
  output logic [W-1:0] o_c
);
  assign o_s = i_x ^ i_y ^ i_z;
  // Carry out of bit W-1 is dropped; the product never reaches 2^W.
  assign o_c = ((i_x & i_y) | (i_x & i_z) | (i_y & i_z)) << 1;
endmodule

module wallace_csa_reducer #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] sum_vec,
  output logic [2*N-1:0] carry_vec,
  output logic           busy
);
  localparam int W = 2 * N;
  localparam int G = N / 3;

  typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [N-1:0][W-1:0] r_row, w_nxt, w_pp;
  logic [G-1:0][W-1:0] w_s, w_c;
  logic [4:0]          r_cnt, w_cnt_nxt;
  logic                w_accept;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_pp
      assign w_pp[gi] = b[gi] ? (W'(a) << gi) : '0;
    end
    // Groups always sit at rows 3g..3g+2, so each CSA is hard-wired to its rows.
    for (gi = 0; gi < G; gi++) begin : g_csa
      wallace_csa_row #(.W(W)) u_csa (
        .i_x(r_row[3*gi]),
        .i_y(r_row[3*gi+1]),
        .i_z(r_row[3*gi+2]),
        .o_s(w_s[gi]),
        .o_c(w_c[gi])
      );
    end
  endgenerate

  // Pack layer results from row 0: (s,c) per full group, then leftover rows.
  always_comb begin
    w_nxt     = '0;
    w_cnt_nxt = r_cnt;
    case (r_cnt)
      5'd16: begin
        w_nxt[0] = w_s[0]; w_nxt[1] = w_c[0]; w_nxt[2] = w_s[1]; w_nxt[3] = w_c[1];
        w_nxt[4] = w_s[2]; w_nxt[5] = w_c[2]; w_nxt[6] = w_s[3]; w_nxt[7] = w_c[3];
        w_nxt[8] = w_s[4]; w_nxt[9] = w_c[4]; w_nxt[10] = r_row[15];
        w_cnt_nxt = 5'd11;
      end
      5'd11: begin
        w_nxt[0] = w_s[0]; w_nxt[1] = w_c[0]; w_nxt[2] = w_s[1]; w_nxt[3] = w_c[1];
        w_nxt[4] = w_s[2]; w_nxt[5] = w_c[2]; w_nxt[6] = r_row[9]; w_nxt[7] = r_row[10];
        w_cnt_nxt = 5'd8;
      end
      5'd8: begin
        w_nxt[0] = w_s[0]; w_nxt[1] = w_c[0]; w_nxt[2] = w_s[1]; w_nxt[3] = w_c[1];
        w_nxt[4] = r_row[6]; w_nxt[5] = r_row[7];
        w_cnt_nxt = 5'd6;
      end
      5'd6: begin
        w_nxt[0] = w_s[0]; w_nxt[1] = w_c[0]; w_nxt[2] = w_s[1]; w_nxt[3] = w_c[1];
        w_cnt_nxt = 5'd4;
      end
      5'd4: begin
        w_nxt[0] = w_s[0]; w_nxt[1] = w_c[0]; w_nxt[2] = r_row[3];
        w_cnt_nxt = 5'd3;
      end
      5'd3: begin
        w_nxt[0] = w_s[0]; w_nxt[1] = w_c[0];
        w_cnt_nxt = 5'd2;
      end
      default: begin
        w_nxt     = r_row;
        w_cnt_nxt = r_cnt;
      end
    endcase
  end

  assign in_ready = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = REDUCE;
      REDUCE:  if (w_cnt_nxt == 5'd2) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = in_valid ? REDUCE : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_row <= w_pp;
        r_cnt <= 5'd16;
      end else if (r_state == REDUCE) begin
        r_row <= w_nxt;
        r_cnt <= w_cnt_nxt;
      end
    end
  end

  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign sum_vec   = out_valid ? r_row[0] : '0;
  assign carry_vec = out_valid ? r_row[1] : '0;
endmodule

// File: tb/tb_wallace_csa_reducer.sv
// Bench for wallace_csa_reducer: directed vector table, handshake corner sequences,
// and random operands checked against the plain product a*b.
module tb_wallace_csa_reducer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] sum_vec;
  logic [31:0] carry_vec;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  wallace_csa_reducer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_vec(sum_vec), .carry_vec(carry_vec), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Drive operands and take the accept edge; returns #1 after that edge.
  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_, input string nm);
    a = ta; b = tb_; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF;
    chk({nm, " busy"}, 64'(busy), 64'd1);
    chk({nm, " out_valid early"}, 64'(out_valid), 64'd0);
  endtask

  task automatic wait_done(input logic [31:0] exp, input string nm);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'd6);
    chk({nm, " pair sum"}, 64'({1'b0, sum_vec} + {1'b0, carry_vec}), 64'({1'b0, exp}));
  endtask

  task automatic finish_op(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, " out_valid after xfer"}, 64'(out_valid), 64'd0);
    chk({nm, " idle in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] hs, hc;
    logic [15:0] ra, rb;

    tbl[0] = '{16'h0003, 16'h0005, 32'h0000000F};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    tbl[2] = '{16'h1234, 16'h0000, 32'h00000000};
    tbl[3] = '{16'h0001, 16'hABCD, 32'h0000ABCD};
    tbl[4] = '{16'h00FF, 16'h0101, 32'h0000FFFF};
    tbl[5] = '{16'h8000, 16'h8001, 32'h40008000};

    #12;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst vecs", {sum_vec, carry_vec}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      start_op(tbl[i].a, tbl[i].b, $sformatf("tbl%0d", i));
      wait_done(tbl[i].p, $sformatf("tbl%0d", i));
      if (tbl[i].b == 16'h0) chk("zero vecs", {sum_vec, carry_vec}, 64'd0);
      finish_op($sformatf("tbl%0d", i));
    end

    // Backpressure: DONE held 10 cycles while a competing request is presented.
    start_op(16'h1357, 16'h2468, "bp");
    wait_done(32'h1357 * 32'h2468, "bp");
    hs = sum_vec; hc = carry_vec;
    in_valid = 1'b1; a = 16'h0F0F; b = 16'h00F0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp out_valid", 64'(out_valid), 64'd1);
      chk("bp hold", {sum_vec, carry_vec}, {hs, hc});
      chk("bp in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    finish_op("bp");

    // Back-to-back: new accept on the same edge as the output transfer.
    start_op(16'h0001, 16'hABCD, "b2b0");
    wait_done(32'h0000ABCD, "b2b0");
    out_ready = 1'b1; in_valid = 1'b1; a = 16'h00FF; b = 16'h0101;
    #1;
    chk("b2b in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    chk("b2b reaccept busy", 64'(busy), 64'd1);
    chk("b2b out_valid low", 64'(out_valid), 64'd0);
    wait_done(32'h0000FFFF, "b2b1");
    finish_op("b2b1");

    // Async reset during layer 3 discards the operation.
    start_op(16'hAAAA, 16'h5555, "rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid rst out_valid", 64'(out_valid), 64'd0);
    chk("mid rst busy", 64'(busy), 64'd0);
    chk("mid rst vecs", {sum_vec, carry_vec}, 64'd0);
    chk("mid rst in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (8) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      chk("no output after rst", 64'(seen), 64'd0);
    end
    start_op(16'd7, 16'd9, "post rst");
    wait_done(32'd63, "post rst");
    finish_op("post rst");

    // Random operands against the plain product, with random output stalls.
    for (int r = 0; r < 25; r++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (r == 0) ra = 16'hFFFF;
      start_op(ra, rb, "rnd");
      wait_done(32'(ra) * 32'(rb), $sformatf("rnd%0d %h*%h", r, ra, rb));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      chk("rnd stall valid", 64'(out_valid), 64'd1);
      finish_op("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
